// File: rtl/stepdown_corestate_seq.sv
// Core-state sequencer for the STEPDOWN buck brick: driver enable, soft-start ramp, OC hiccup, power-good.
// Optional macro STEPDOWN_PGOOD_DEGLITCH_EN adds a consecutive-fb_ok deglitch counter ahead of pgood.
module stepdown_corestate_seq #(
    parameter int RAMP_W      = 4,
    parameter int SS_DIV      = 4,
    parameter int OC_LIMIT    = 3,
    parameter int RETRY_CYC   = 32,
    parameter int PG_DEGLITCH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en,
    input  logic              uvlo_n,
    input  logic              oc,
    input  logic              fb_ok,
    output logic              drv_en,
    output logic [RAMP_W-1:0] ss_code,
    output logic              pgood,
    output logic              fault,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_SS    = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int PS_W = (SS_DIV > 1) ? $clog2(SS_DIV) : 1;
    localparam int OC_W = $clog2(OC_LIMIT + 1);
    localparam int RT_W = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
    localparam logic [RAMP_W-1:0] SS_MAX  = '1;
    localparam logic [PS_W-1:0]   PS_TERM = PS_W'(SS_DIV - 1);
    localparam logic [OC_W-1:0]   OC_MAX  = OC_W'(OC_LIMIT);
    localparam logic [RT_W-1:0]   RT_TERM = RT_W'(RETRY_CYC - 1);

    // Supply/substrate pins are electrical pass-throughs only.
    logic unused_pins;
    assign unused_pins = &{1'b0, CELV, CELG, SUB};

    state_t            cur, nxt;
    logic [RAMP_W-1:0] ss_n;
    logic [PS_W-1:0]   ps, ps_n;
    logic [OC_W-1:0]   oc_cnt, oc_n, oc_inc;
    logic [RT_W-1:0]   retry, retry_n;
    logic              pgood_n;
    logic              active;

`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
    localparam int PG_W = $clog2(PG_DEGLITCH + 1);
    localparam logic [PG_W-1:0] PG_MAX = PG_W'(PG_DEGLITCH);
    logic [PG_W-1:0] pg_cnt, pg_cnt_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= S_OFF;
            ss_code <= '0;
            ps      <= '0;
            oc_cnt  <= '0;
            retry   <= '0;
            pgood   <= 1'b0;
            drv_en  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            cur     <= nxt;
            ss_code <= ss_n;
            ps      <= ps_n;
            oc_cnt  <= oc_n;
            retry   <= retry_n;
            pgood   <= pgood_n;
            drv_en  <= (nxt == S_SS) || (nxt == S_RUN);
            fault   <= (nxt == S_FAULT);
        end
    end

`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pg_cnt <= '0;
        else     pg_cnt <= pg_cnt_n;
    end
`endif

    always_comb begin
        nxt     = cur;
        ss_n    = ss_code;
        ps_n    = ps;
        oc_n    = '0;
        retry_n = '0;
        pgood_n = 1'b0;
        active  = 1'b0;
        oc_inc  = (oc_cnt == OC_MAX) ? oc_cnt : oc_cnt + 1'b1;
`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
        pg_cnt_n = '0;
`endif
        case (cur)
            S_OFF: begin
                ss_n = '0;
                ps_n = '0;
                if (en && uvlo_n) nxt = S_SS;
            end
            S_SS: begin
                active = 1'b1;
                if (ps == PS_TERM) begin
                    ps_n = '0;
                    if (ss_code != SS_MAX) ss_n = ss_code + 1'b1;
                    else                   nxt  = S_RUN;
                end else begin
                    ps_n = ps + 1'b1;
                end
            end
            S_RUN: begin
                active = 1'b1;
                ss_n   = SS_MAX;
                ps_n   = '0;
`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
                pg_cnt_n = !fb_ok ? '0 : (pg_cnt == PG_MAX) ? pg_cnt : pg_cnt + 1'b1;
                pgood_n  = (pg_cnt_n == PG_MAX);
`else
                pgood_n = fb_ok;
`endif
            end
            default: begin
                ss_n = '0;
                ps_n = '0;
                if (retry == RT_TERM) nxt     = S_OFF;
                else                  retry_n = retry + 1'b1;
            end
        endcase

        // Overcurrent trip then disable, so disable takes priority on a shared edge.
        if (active) begin
            oc_n = oc ? oc_inc : '0;
            if (oc_n == OC_MAX || !en || !uvlo_n) begin
                nxt     = (!en || !uvlo_n) ? S_OFF : S_FAULT;
                ss_n    = '0;
                ps_n    = '0;
                oc_n    = '0;
                pgood_n = 1'b0;
`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
                pg_cnt_n = '0;
`endif
            end
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Directed self-checking bench for stepdown_corestate_seq using default parameters.
module tb_stepdown_corestate_seq;
    logic       clk, rst, en, uvlo_n, oc, fb_ok;
    logic       drv_en, pgood, fault;
    logic [3:0] ss_code;
    logic [1:0] state;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef STEPDOWN_PGOOD_DEGLITCH_EN
    localparam int PG_LAT = 8;
`else
    localparam int PG_LAT = 1;
`endif

    stepdown_corestate_seq dut (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .uvlo_n(uvlo_n), .oc(oc), .fb_ok(fb_ok),
        .drv_en(drv_en), .ss_code(ss_code), .pgood(pgood), .fault(fault), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic dv,
                             input logic [3:0] ss, input logic pg, input logic ft);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".drv_en"}, 32'(drv_en), 32'(dv));
        check({tag, ".ss_code"}, 32'(ss_code), 32'(ss));
        check({tag, ".pgood"}, 32'(pgood), 32'(pg));
        check({tag, ".fault"}, 32'(fault), 32'(ft));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; uvlo_n = 1'b1; oc = 1'b0; fb_ok = 1'b1;
        tick();
        tick();
        check_all("reset", 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Nominal start
        rst = 1'b0; en = 1'b1;
        tick();
        check_all("ss_entry", 2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i < 64) begin
                check("ramp.state", 32'(state), 32'd1);
                check("ramp.ss_code", 32'(ss_code), 32'(i / 4));
            end
        end
        check_all("run_entry", 2'd2, 1'b1, 4'd15, 1'b0, 1'b0);
        for (int i = 1; i < PG_LAT; i++) begin
            tick();
            check("pg_wait", 32'(pgood), 32'd0);
        end
        tick();
        check_all("run_pgood", 2'd2, 1'b1, 4'd15, 1'b1, 1'b0);
        fb_ok = 1'b0;
        tick();
        check("pgood_drop", 32'(pgood), 32'd0);
        fb_ok = 1'b1;
        for (int i = 0; i < PG_LAT; i++) tick();
        check("pgood_back", 32'(pgood), 32'd1);

        // OC glitch pattern 1,1,0,1,1
        for (int i = 0; i < 5; i++) begin
            oc = (i != 2);
            tick();
            check("glitch.state", 32'(state), 32'd2);
            check("glitch.drv_en", 32'(drv_en), 32'd1);
        end
        oc = 1'b0;
        tick();

        // OC hiccup with uvlo_n toggling during FAULT
        oc = 1'b1;
        tick();
        check("oc1.state", 32'(state), 32'd2);
        tick();
        check("oc2.state", 32'(state), 32'd2);
        tick();
        oc = 1'b0;
        check_all("fault_entry", 2'd3, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            uvlo_n = (i < 32) ? logic'(i % 2) : 1'b1;
            tick();
            if (i < 32) check("fault.state", 32'(state), 32'd3);
        end
        check_all("retry_off", 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        check_all("retry_ss", 2'd1, 1'b1, 4'd0, 1'b0, 1'b0);

        // Disable mid-ramp at ss_code=7
        for (int i = 0; i < 28; i++) tick();
        check("mid.ss_code", 32'(ss_code), 32'd7);
        en = 1'b0;
        tick();
        check_all("disable", 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        check_all("restart", 2'd1, 1'b1, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("restart.ss3", 32'(ss_code), 32'd0);
        tick();
        check("restart.ss4", 32'(ss_code), 32'd1);

        // uvlo_n drop on the same edge as the third oc-high cycle
        for (int i = 0; i < 60; i++) tick();
        check("run2.state", 32'(state), 32'd2);
        oc = 1'b1;
        tick();
        tick();
        uvlo_n = 1'b0;
        tick();
        oc = 1'b0; uvlo_n = 1'b1;
        check_all("simul", 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges while in RUN with pgood high
        tick();
        for (int i = 0; i < 64 + PG_LAT; i++) tick();
        check_all("run3", 2'd2, 1'b1, 4'd15, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 2'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst.state", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
